alu_exec_core: RTL and testbench

Execution stage of the ALU datapath: accepts one operation and two operands per transaction through a valid/ready handshake from the alu_in agent side. It computes the result, with single-pass logic/add and iterative shift-add multiply. It presents the result on the alu_out bus as a one-cycle `done` pulse with a held `result`, and is the producer that the alu_out monitor/initiator observes.

---
 rtl/alu_exec_core.sv | 157 +++++++++++++++
 tb/tb_alu_exec_core.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_exec_core : ALU execution stage, single-pass add/and/xor, shift-add mul
// Revision      : 1.0
// ---------------------------------------------------------------------------
module alu_exec_core #(
    parameter int ALU_IN_OPERAND_WIDTH = 8,
    parameter int ALU_OUT_RESULT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid,
    input  logic [2:0]                      op,
    input  logic [ALU_IN_OPERAND_WIDTH-1:0] a,
    input  logic [ALU_IN_OPERAND_WIDTH-1:0] b,
    output logic                            ready,
    output logic                            done,
    output logic [ALU_OUT_RESULT_WIDTH-1:0] result
);

    localparam int c_W  = ALU_IN_OPERAND_WIDTH;
    localparam int c_PW = 2 * c_W;
    localparam int c_R  = ALU_OUT_RESULT_WIDTH;
    localparam int c_CW = (c_W > 1) ? $clog2(c_W) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_W - 1);

    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_MUL = 3'b100;
    localparam logic [2:0] c_OP_RST = 3'b111;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_EXEC = 3'd1;
    localparam logic [2:0] c_S_MUL  = 3'd2;
    localparam logic [2:0] c_S_LOAD = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    generate
        if (ALU_OUT_RESULT_WIDTH < 2 * ALU_IN_OPERAND_WIDTH) begin : g_width_check
            $error("ALU_OUT_RESULT_WIDTH must be at least 2*ALU_IN_OPERAND_WIDTH");
        end
    endgenerate

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [2:0]      r_op;
    logic [c_W-1:0]  r_a;
    logic [c_W-1:0]  r_b;
    logic [c_CW-1:0] r_cnt;
    logic [c_PW-1:0] r_acc;
    logic [c_R-1:0]  r_result;
    logic            r_ready;
    logic            r_done;

    logic            w_accept;
    logic            w_ready_nxt;
    logic            w_done_nxt;
    logic            w_mul_step;
    logic            w_exec_step;
    logic            w_load;
    logic [c_W:0]    w_sum;
    logic [c_PW-1:0] w_logic;
    logic [c_PW-1:0] w_partial;

    assign w_accept  = valid && r_ready && (r_state == c_S_IDLE);
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_partial = r_b[r_cnt] ? (c_PW'(r_a) << r_cnt) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Mul leaves through EXEC as a settle cycle so every op shares the LOAD/DONE tail.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    case (op)
                        c_OP_ADD, c_OP_AND, c_OP_XOR: w_next = c_S_EXEC;
                        c_OP_MUL:                     w_next = c_S_MUL;
                        default:                      w_next = c_S_IDLE;
                    endcase
                end
            end
            c_S_EXEC: w_next = c_S_LOAD;
            c_S_MUL:  w_next = (r_cnt == c_CNT_LAST) ? c_S_EXEC : c_S_MUL;
            c_S_LOAD: w_next = c_S_DONE;
            c_S_DONE: w_next = c_S_IDLE;
            default:  w_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_ready_nxt = (w_next == c_S_IDLE);
        w_done_nxt  = (w_next == c_S_DONE);
        w_mul_step  = (r_state == c_S_MUL);
        w_exec_step = (r_state == c_S_EXEC) && (r_op != c_OP_MUL);
        w_load      = (r_state == c_S_LOAD);
    end

    always_comb begin
        w_logic = '0;
        case (r_op)
            c_OP_ADD: w_logic = c_PW'(w_sum);
            c_OP_AND: w_logic = c_PW'(r_a & r_b);
            c_OP_XOR: w_logic = c_PW'(r_a ^ r_b);
            default:  w_logic = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_op  <= op;
                r_a   <= a;
                r_b   <= b;
                r_cnt <= '0;
                r_acc <= '0;
            end
            if (w_mul_step) begin
                r_acc <= r_acc + w_partial;
                r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
            if (w_exec_step) begin
                r_acc <= w_logic;
            end
            if (w_load) begin
                r_result <= c_R'(r_acc);
            end else if (w_accept && (op == c_OP_RST)) begin
                r_result <= '0;
            end
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_exec_core : directed + randomized checks against a transaction model
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_alu_exec_core;

    localparam int c_W = 8;
    localparam int c_R = 16;

    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_MUL = 3'b100;
    localparam logic [2:0] c_OP_ILL = 3'b101;
    localparam logic [2:0] c_OP_RST = 3'b111;

    logic           clk   = 1'b0;
    logic           rst   = 1'b0;
    logic           valid = 1'b0;
    logic [2:0]     op    = '0;
    logic [c_W-1:0] a     = '0;
    logic [c_W-1:0] b     = '0;
    logic           ready;
    logic           done;
    logic [c_R-1:0] result;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [c_R-1:0] m_result = '0;

    always #5 clk = ~clk;

    alu_exec_core #(
        .ALU_IN_OPERAND_WIDTH(c_W),
        .ALU_OUT_RESULT_WIDTH(c_R)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: updates the expected result and says whether/when done fires.
    task automatic ref_op(input logic [2:0] o, input logic [c_W-1:0] x, input logic [c_W-1:0] y,
                          output bit fires, output int lat);
        fires = 1'b1;
        lat   = 2;
        case (o)
            c_OP_ADD: m_result = c_R'(int'(x) + int'(y));
            c_OP_AND: m_result = c_R'(x & y);
            c_OP_XOR: m_result = c_R'(x ^ y);
            c_OP_MUL: begin
                m_result = c_R'(int'(x) * int'(y));
                lat      = c_W + 2;
            end
            c_OP_RST: begin
                m_result = '0;
                fires    = 1'b0;
            end
            default:  fires = 1'b0;
        endcase
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 40 && ready !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        check(tag, ready, 1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [c_W-1:0] x, input logic [c_W-1:0] y);
        bit             fires;
        int             lat;
        logic [c_R-1:0] prev;
        wait_ready("pre_ready");
        prev = m_result;
        ref_op(o, x, y, fires, lat);
        valid = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = 3'($urandom);
        a     = c_W'($urandom);
        b     = c_W'($urandom);
        if (!fires) begin
            check("nodone_done", done, 0);
            check("nodone_ready", ready, 1);
            check("nodone_result", result, m_result);
            return;
        end
        for (int k = 0; k < lat; k++) begin
            check("busy_ready", ready, 0);
            check("busy_done", done, 0);
            check("busy_result", result, prev);
            @(posedge clk);
            #1;
        end
        check("done_pulse", done, 1);
        check("done_result", result, m_result);
        check("done_ready", ready, 0);
        @(posedge clk);
        #1;
        check("after_done", done, 0);
        check("after_ready", ready, 1);
        check("after_result", result, m_result);
    endtask

    task automatic held_valid_test();
        bit fires;
        int lat;
        int e;
        int extra;
        wait_ready("hv_pre");
        ref_op(c_OP_MUL, 8'h12, 8'h34, fires, lat);
        valid = 1'b1;
        op    = c_OP_MUL;
        a     = 8'h12;
        b     = 8'h34;
        @(posedge clk);
        #1;
        op    = c_OP_ADD;
        a     = 8'h05;
        b     = 8'h03;
        e     = 0;
        extra = 0;
        while (ready !== 1'b1 && e < 40) begin
            @(posedge clk);
            #1;
            e++;
            if (e == c_W + 2) begin
                check("hv_mul_done", done, 1);
                check("hv_mul_result", result, m_result);
            end else if (done === 1'b1) begin
                extra++;
            end
        end
        check("hv_ready_latency", e, c_W + 3);
        check("hv_extra_done", extra, 0);
        ref_op(c_OP_ADD, 8'h05, 8'h03, fires, lat);
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("hv_add_busy", ready, 0);
        @(posedge clk);
        #1;
        check("hv_add_nodone", done, 0);
        @(posedge clk);
        #1;
        check("hv_add_done", done, 1);
        check("hv_add_result", result, m_result);
    endtask

    task automatic mid_reset_test();
        int pulses;
        wait_ready("mr_pre");
        valid = 1'b1;
        op    = c_OP_MUL;
        a     = 8'h12;
        b     = 8'h34;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        m_result = '0;
        check("mr_ready", ready, 0);
        check("mr_done", done, 0);
        check("mr_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mr_ready_rise", ready, 1);
        pulses = 0;
        for (int k = 0; k < c_W + 6; k++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        check("mr_no_done", pulses, 0);
        check("mr_result_after", result, 0);
    endtask

    initial begin
        #2;
        rst = 1'b1;
        #1;
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready_rise", ready, 1);

        run_op(c_OP_ADD, 8'hFF, 8'h01);
        check("add_ff_01", result, 16'h0100);
        run_op(c_OP_AND, 8'hF0, 8'h3C);
        check("and_f0_3c", result, 16'h0030);
        run_op(c_OP_XOR, 8'hF0, 8'h3C);
        check("xor_f0_3c", result, 16'h00CC);
        run_op(c_OP_MUL, 8'hFF, 8'hFF);
        check("mul_ff_ff", result, 16'hFE01);
        run_op(c_OP_MUL, 8'h00, 8'h7B);
        check("mul_00_7b", result, 16'h0000);
        run_op(c_OP_ADD, 8'hFF, 8'h01);
        run_op(c_OP_RST, 8'h11, 8'h22);
        check("rstop_result", result, 16'h0000);
        run_op(c_OP_ADD, 8'h80, 8'h80);
        run_op(c_OP_NOP, 8'h33, 8'h44);
        run_op(c_OP_ILL, 8'h55, 8'h66);
        check("nop_keeps", result, 16'h0100);

        held_valid_test();
        mid_reset_test();

        for (int i = 0; i < 60; i++) begin
            logic [2:0] o;
            o = (i % 5 == 0) ? c_OP_MUL : 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op(o, c_W'($urandom), c_W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
